// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with 2-flop line synchronizer.
// Registered done / framing-error pulses; dato_out holds the last good frame.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            tick_in,
    input  logic            dato_in,
    output logic [DBIT-1:0] dato_out,
    output logic            rx_done_tick,
    output logic            framing_error
);
    localparam int NW = $clog2(DBIT) + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_next;
    logic [3:0]      s, s_next;
    logic [NW-1:0]   n, n_next;
    logic [DBIT-1:0] b, b_next, dato_next;
    logic            done_next, ferr_next;
    logic            sync1, line;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1         <= 1'b1;
            line          <= 1'b1;
            state         <= IDLE;
            s             <= '0;
            n             <= '0;
            b             <= '0;
            dato_out      <= '0;
            rx_done_tick  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            sync1         <= dato_in;
            line          <= sync1;
            state         <= state_next;
            s             <= s_next;
            n             <= n_next;
            b             <= b_next;
            dato_out      <= dato_next;
            rx_done_tick  <= done_next;
            framing_error <= ferr_next;
        end
    end

    always_comb begin
        state_next = state;
        s_next     = s;
        n_next     = n;
        b_next     = b;
        dato_next  = dato_out;
        done_next  = 1'b0;
        ferr_next  = 1'b0;
        case (state)
            IDLE: if (!line) begin
                state_next = START;
                s_next     = '0;
            end
            // mid-start-bit check rejects glitches shorter than half a bit
            START: if (tick_in) begin
                if (s == 4'd7) begin
                    state_next = line ? IDLE : DATA;
                    s_next     = '0;
                    n_next     = '0;
                end else s_next = s + 4'd1;
            end
            DATA: if (tick_in) begin
                if (s == 4'd15) begin
                    b_next     = {line, b[DBIT-1:1]};
                    s_next     = '0;
                    state_next = (n == NW'(DBIT - 1)) ? STOP : DATA;
                    n_next     = (n == NW'(DBIT - 1)) ? n : n + NW'(1);
                end else s_next = s + 4'd1;
            end
            STOP: if (tick_in) begin
                if (s == 4'(SB_TICK - 1)) begin
                    state_next = IDLE;
                    dato_next  = line ? b : dato_out;
                    done_next  = line;
                    ferr_next  = !line;
                end else s_next = s + 4'd1;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DBIT, default 8: number of data bits per frame.
REQ-002 Parameter SB_TICK, default 16: tick_in pulses spanning one stop bit.
REQ-003 Port clock  input  1  system clock; all state changes on its rising edge.
REQ-004 Port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 Port tick_in  input  1  16x-baud sampling enable, one clock cycle wide per pulse.
REQ-006 Port dato_in  input  1  serial receive line; idle high, LSB first, 1 start bit, DBIT data bits, 1 stop bit, no parity.
REQ-007 Port dato_out  output  DBIT  last correctly framed received byte.
REQ-008 Port rx_done_tick  output  1  one-cycle pulse when dato_out is updated.
REQ-009 Port framing_error  output  1  one-cycle pulse when the stop bit samples low.

Function
REQ-010 dato_in SHALL pass through a 2-flop synchronizer (reset value 1) before any use; "line" below means the synchronized value.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP; registers: 4-bit tick counter s, bit counter n (width ceil(log2(DBIT))+1), DBIT-bit shift register b.
REQ-012 IDLE: when line is 0 at a clock edge, go to START with s=0; tick_in is ignored in IDLE.
REQ-013 START: on each tick_in, if s==7 then check line: 0 -> DATA with s=0, n=0; 1 -> IDLE (glitch rejected, no outputs pulse); otherwise s=s+1.
REQ-014 DATA: on each tick_in, if s==15 then shift line into b MSB (b = {line, b[DBIT-1:1]}), s=0, and if n==DBIT-1 go to STOP else n=n+1; otherwise s=s+1.
REQ-015 STOP: on each tick_in, if s==SB_TICK-1 then sample line and go to IDLE; otherwise s=s+1.
REQ-016 Stop sample 1: dato_out SHALL load b and rx_done_tick SHALL be 1 for exactly the following clock cycle.
REQ-017 Stop sample 0: framing_error SHALL be 1 for exactly the following clock cycle; dato_out SHALL keep its previous value; rx_done_tick stays 0.
REQ-018 rx_done_tick and framing_error SHALL never both be 1 and SHALL be registered outputs.
REQ-019 Counters SHALL advance only on cycles with tick_in=1 (outside IDLE); cycles without tick_in hold all state.
REQ-020 A line held low through STOP (break) SHALL yield one framing_error, return to IDLE, then re-enter START immediately because line is still 0; no further pulses until a valid start bit completes.
REQ-021 After STOP returns to IDLE, a new start edge SHALL be accepted on the very next clock (back-to-back frames with no idle gap).

Reset
REQ-022 reset_n=0 SHALL immediately force state IDLE, s=0, n=0, b=0, dato_out=0, rx_done_tick=0, framing_error=0, synchronizer flops=1.
REQ-023 Reset asserted mid-frame SHALL abandon the frame with no pulse; after release, reception restarts on the next falling edge of line.

Verification
REQ-024 Frame 0x25 (line bits 0,1,0,1,0,0,1,0,0,1) at 16 ticks/bit -> one rx_done_tick, dato_out=0x25, framing_error never 1.
REQ-025 Low pulse of 4 ticks then line high -> state back to IDLE after START check, no rx_done_tick, no framing_error, dato_out unchanged.
REQ-026 Frame 0xA5 with stop bit driven 0 -> one framing_error pulse, no rx_done_tick, dato_out keeps prior value (0x25).
REQ-027 Frames 0x00 then 0xFF back-to-back, zero idle bits -> two rx_done_tick pulses, dato_out 0x00 then 0xFF.
REQ-028 reset_n pulsed low during DATA bit 3 of frame 0x5A, then full frame 0x3C -> no pulse for 0x5A, dato_out=0 after reset, then dato_out=0x3C with one rx_done_tick.
REQ-029 tick_in gaps of random 1-5 idle clocks between ticks with frame 0xC3 -> dato_out=0xC3, one rx_done_tick.
